// File: rtl/fifo_mem_ctrl.sv
// fifo_mem_ctrl: sequences an 8-entry dual-address memory as a FIFO.
// Drives the memory strobes/addresses combinationally from the accepted
// push/pop of the current cycle, tracks occupancy, decodes status flags
// from the registered count and re-times memory read data to the consumer.
module fifo_mem_ctrl #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   th_high,
  input  logic [ADDR_WIDTH:0]   th_low,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_valid_out,
  input  logic                  mem_err,
  output logic                  write,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] address_write,
  output logic [ADDR_WIDTH-1:0] address_read,
  output logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic                  idle
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_th_high;
  logic [ADDR_WIDTH:0]   r_th_low;
  logic                  r_rd_pend;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;

  logic                  w_run;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_ovf;
  logic                  w_unf;
  logic                  w_fault;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_cfg_ok;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic [1:0]            w_state_nxt;

  // Accept decode: any fault in a cycle cancels both requests of that cycle,
  // so an overflow/underflow never moves pointers or touches the memory.
  always_comb begin
    w_run       = (r_state == S_IDLE) || (r_state == S_ACTIVE);
    w_full      = (r_count == DEPTH_C);
    w_empty     = (r_count == '0);
    w_ovf       = push & w_full;
    w_unf       = pop & w_empty;
    w_fault     = w_run & (w_ovf | w_unf | mem_err);
    w_push_ok   = w_run & push & ~w_full & ~w_fault;
    w_pop_ok    = w_run & pop & ~w_empty & ~w_fault;
    w_count_nxt = r_count + (ADDR_WIDTH+1)'(w_push_ok) - (ADDR_WIDTH+1)'(w_pop_ok);
    w_cfg_ok    = (th_low < th_high) && (th_high <= DEPTH_C);
  end

  // Next-state: ACTIVE is held while the last popped word is still in flight
  // so idle only asserts once the read pipeline has drained.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:   w_state_nxt = w_cfg_ok ? S_IDLE : S_ERROR;
      S_IDLE: begin
        if (w_fault)        w_state_nxt = S_ERROR;
        else if (w_push_ok) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_fault)                                 w_state_nxt = S_ERROR;
        else if ((w_count_nxt == '0) && !w_pop_ok)   w_state_nxt = S_IDLE;
      end
      S_ERROR:  w_state_nxt = S_ERROR;
      default:  w_state_nxt = S_ERROR;
    endcase
  end

  // FSM state register; ERROR is only left through RESET.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  // Thresholds are captured once, in the INIT cycle. The reset values keep
  // almost_full low and almost_empty high until then.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_th_high <= '1;
      r_th_low  <= '0;
    end else if (r_state == S_INIT) begin
      r_th_high <= th_high;
      r_th_low  <= th_low;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_count <= w_count_nxt;
    end
  end

  // Read return path: only a valid that answers our own read is forwarded,
  // which also drops a stale valid from before a reset.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_rd_pend   <= 1'b0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_rd_pend   <= w_pop_ok;
      r_valid_out <= mem_valid_out & r_rd_pend;
      if (mem_valid_out & r_rd_pend) r_data_out <= mem_data_out;
    end
  end

  // Output drive: memory strobes follow this cycle's accepted requests.
  always_comb begin
    write         = w_push_ok;
    read          = w_pop_ok;
    address_write = r_wr_ptr;
    address_read  = r_rd_ptr;
    data          = w_push_ok ? data_in : '0;
    data_out      = r_data_out;
    valid_out     = r_valid_out;
    fifo_count    = r_count;
    full          = w_full;
    empty         = w_empty;
    almost_full   = (r_count >= r_th_high);
    almost_empty  = (r_count <= r_th_low);
    error         = (r_state == S_ERROR);
    idle          = (r_state == S_IDLE);
  end

  a_count_range: assert property (@(posedge clk) disable iff (RESET)
    r_count <= DEPTH_C);
  a_err_quiet: assert property (@(posedge clk) disable iff (RESET)
    (r_state == S_ERROR) |-> !(write || read));

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// tb_fifo_mem_ctrl: directed test-plan steps followed by randomized traffic,
// every cycle compared against a queue-based FIFO model.
module tb_fifo_mem_ctrl;

  logic       clk = 1'b0;
  logic       RESET;
  logic       push, pop, mem_err;
  logic [5:0] data_in;
  logic [3:0] th_high, th_low;
  logic [5:0] mem_data_out;
  logic       mem_valid_out;
  logic       write, read;
  logic [2:0] address_write, address_read;
  logic [5:0] data, data_out;
  logic       valid_out;
  logic [3:0] fifo_count;
  logic       full, empty, almost_full, almost_empty, error, idle;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_mem_ctrl #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
    .clk(clk), .RESET(RESET), .push(push), .pop(pop), .data_in(data_in),
    .th_high(th_high), .th_low(th_low), .mem_data_out(mem_data_out),
    .mem_valid_out(mem_valid_out), .mem_err(mem_err), .write(write),
    .read(read), .address_write(address_write), .address_read(address_read),
    .data(data), .data_out(data_out), .valid_out(valid_out),
    .fifo_count(fifo_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .error(error),
    .idle(idle)
  );

  // Behavioural memory: synchronous write, one-cycle read latency.
  logic [5:0] mem [8];
  logic       mv_q = 1'b0;
  logic [5:0] md_q = 6'd0;
  logic       inj  = 1'b0;
  always @(posedge clk) begin
    if (write) mem[address_write] <= data;
    mv_q <= read;
    if (read) md_q <= mem[address_read];
  end
  assign mem_valid_out = mv_q | inj;
  assign mem_data_out  = md_q;

  // Reference model state
  logic [5:0] mq[$];
  int         m_wp, m_rp;
  bit         m_cfg, m_err, m_s1v, m_prev_rok, e_vo, e_pok, e_rok;
  logic [5:0] m_s1d, e_do;
  logic [3:0] m_thh, m_thl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int cnt, input logic [5:0] d);
    bit run;
    run = m_cfg && !m_err;
    chk("write", write, e_pok);
    chk("read", read, e_rok);
    chk("address_write", address_write, m_wp);
    chk("address_read", address_read, m_rp);
    chk("data", data, e_pok ? d : 6'd0);
    chk("fifo_count", fifo_count, cnt);
    chk("full", full, cnt == 8);
    chk("empty", empty, cnt == 0);
    chk("almost_full", almost_full, m_cfg ? (cnt >= m_thh) : 1'b0);
    chk("almost_empty", almost_empty, m_cfg ? (cnt <= m_thl) : 1'b1);
    chk("error", error, m_err);
    chk("idle", idle, run && cnt == 0 && !m_prev_rok);
    chk("valid_out", valid_out, e_vo);
    chk("data_out", data_out, e_do);
  endtask

  // One clock: apply inputs, check at negedge, advance the model at the edge.
  task automatic cyc(input bit p, input bit q, input logic [5:0] d, input bit me);
    int cnt;
    bit run, fl, em, flt;
    logic [5:0] popped;
    push = p; pop = q; data_in = d; mem_err = me;
    @(negedge clk);
    cnt = mq.size();
    run = m_cfg && !m_err;
    fl  = (cnt == 8);
    em  = (cnt == 0);
    flt = run && ((p && fl) || (q && em) || me);
    e_pok = run && p && !fl && !flt;
    e_rok = run && q && !em && !flt;
    check_all(cnt, d);
    popped = em ? 6'd0 : mq[0];
    if (!m_cfg) begin
      m_cfg = 1'b1;
      m_thh = th_high;
      m_thl = th_low;
      if (!(th_low < th_high && th_high <= 8)) m_err = 1'b1;
    end else if (flt) begin
      m_err = 1'b1;
    end else if (run) begin
      if (e_rok) begin void'(mq.pop_front()); m_rp = (m_rp + 1) % 8; end
      if (e_pok) begin mq.push_back(d); m_wp = (m_wp + 1) % 8; end
    end
    e_vo = m_s1v;
    if (m_s1v) e_do = m_s1d;
    m_s1v = e_rok;
    m_s1d = popped;
    m_prev_rok = e_rok;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [3:0] hi, input logic [3:0] lo);
    RESET = 1'b1; push = 0; pop = 0; mem_err = 0; data_in = 0; inj = 0;
    th_high = hi; th_low = lo;
    mq.delete();
    m_wp = 0; m_rp = 0; m_cfg = 0; m_err = 0; m_s1v = 0; m_prev_rok = 0;
    e_vo = 0; e_do = 0; e_pok = 0; e_rok = 0; m_s1d = 0; m_thh = 0; m_thl = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all(0, 6'd0);
    @(posedge clk); #1;
    RESET = 1'b0;
  endtask

  initial begin
    int hi, lo;
    bit p, q;
    // Fill to full with 0x01..0x08
    do_reset(4'd6, 4'd2);
    cyc(0, 0, 0, 0);
    chk("idle_after_init", idle, 1'b1);
    for (int i = 1; i <= 8; i++) cyc(1, 0, 6'(i), 0);
    chk("count_full", fifo_count, 4'd8);
    chk("full_flag", full, 1'b1);
    chk("almost_full_flag", almost_full, 1'b1);
    // Drain 8
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("empty_end", empty, 1'b1);
    chk("idle_end", idle, 1'b1);
    chk("last_data_out", data_out, 6'h08);
    // Wrap: push 5, pop 5, push 6, pop 6
    for (int i = 0; i < 5; i++) cyc(1, 0, 6'(8'h10 + i), 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    chk("wr_ptr_at_5", address_write, 3'd5);
    for (int i = 0; i < 6; i++) cyc(1, 0, 6'(8'h20 + i), 0);
    chk("wr_ptr_wrapped", address_write, 3'd3);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("wrap_count0", fifo_count, 4'd0);
    // Simultaneous push/pop at count 3
    for (int i = 0; i < 3; i++) cyc(1, 0, 6'(8'h30 + i), 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 6'(8'h38 + i), 0);
    chk("simul_count", fifo_count, 4'd3);
    chk("simul_noerr", error, 1'b0);
    // Overflow with pop also high
    for (int i = 0; i < 5; i++) cyc(1, 0, 6'(i), 0);
    cyc(1, 1, 6'h3f, 0);
    repeat (3) cyc(1, 1, 6'h15, 0);
    chk("ovf_error", error, 1'b1);
    chk("ovf_count_frozen", fifo_count, 4'd8);
    // Underflow
    do_reset(4'd6, 4'd2);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 6'h2a, 0);
    repeat (2) cyc(0, 0, 0, 0);
    chk("unf_error", error, 1'b1);
    // mem_err
    do_reset(4'd6, 4'd2);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 6'h05, 0);
    cyc(0, 0, 0, 1);
    repeat (2) cyc(1, 0, 6'h06, 0);
    chk("memerr_error", error, 1'b1);
    // Bad configurations
    do_reset(4'd3, 4'd5);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 6'h01, 0);
    chk("cfg_bad_error", error, 1'b1);
    do_reset(4'd9, 4'd2);
    cyc(0, 0, 0, 0);
    chk("cfg_th9_error", error, 1'b1);
    // Edge-valid configuration th_high=8, th_low=7
    do_reset(4'd8, 4'd7);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 6'(i + 1), 0);
    chk("cfg_edge_noerr", error, 1'b0);
    // Reset mid-stream with a read in flight, then a stray valid
    do_reset(4'd6, 4'd2);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 6'(8'h11 + i), 0);
    cyc(0, 1, 0, 0);
    do_reset(4'd6, 4'd2);
    cyc(0, 0, 0, 0);
    inj = 1'b1;
    cyc(0, 0, 0, 0);
    inj = 1'b0;
    repeat (2) cyc(0, 0, 0, 0);
    chk("midreset_count", fifo_count, 4'd0);
    chk("midreset_valid", valid_out, 1'b0);
    // Randomized legal traffic
    for (int r = 0; r < 4; r++) begin
      hi = $urandom_range(1, 8);
      lo = $urandom_range(0, hi - 1);
      do_reset(4'(hi), 4'(lo));
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 200; i++) begin
        p = 1'($urandom_range(0, 1));
        q = 1'($urandom_range(0, 1));
        if (mq.size() == 8) p = 0;
        if (mq.size() == 0) q = 0;
        cyc(p, q, 6'($urandom), 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_mem_ctrl.md
Name: fifo_mem_ctrl

Overview:
Controller that sequences the 8-entry, 6-bit dual-address memory block as a FIFO.
- Accepts push/pop requests from the producer/consumer side.
- Generates the memory's write/read strobes and addresses.
- Tracks occupancy, and raises full/empty, almost-full/almost-empty and error flags.
- Forwards memory read data to the consumer with a valid strobe.
- Sits between the traffic sources and the memory instance in the datapath.

Parameters:
- DATA_WIDTH, 6, data word width; equals the memory data width.
- ADDR_WIDTH, 3, memory address width; FIFO depth DEPTH = 2**ADDR_WIDTH = 8.

Ports:
- clk  input  1  single clock, rising edge.
- RESET  input  1  asynchronous reset, active-high.
- push  input  1  producer requests a write of data_in this cycle.
- pop  input  1  consumer requests a read this cycle.
- data_in  input  DATA_WIDTH  producer data.
- th_high  input  ADDR_WIDTH+1  almost-full threshold; sampled in INIT only.
- th_low  input  ADDR_WIDTH+1  almost-empty threshold; sampled in INIT only.
- mem_data_out  input  DATA_WIDTH  memory read data.
- mem_valid_out  input  1  memory read-data valid.
- mem_err  input  1  memory error flag.
- write  output  1  memory write strobe.
- read  output  1  memory read strobe.
- address_write  output  ADDR_WIDTH  memory write address.
- address_read  output  ADDR_WIDTH  memory read address.
- data  output  DATA_WIDTH  memory write data.
- data_out  output  DATA_WIDTH  popped word to consumer.
- valid_out  output  1  data_out valid, one-cycle pulse per popped word.
- fifo_count  output  ADDR_WIDTH+1  occupancy, range 0..8.
- full, empty, almost_full, almost_empty  output  1  status flags.
- error  output  1  sticky error.
- idle  output  1  FSM in IDLE (count 0, no read in flight).

Behaviour:
Reset (async, RESET=1):
- FSM goes to INIT. wr_ptr = rd_ptr = 0, fifo_count = 0.
- write = read = 0, address_write = address_read = 0, data = 0.
- data_out = 0, valid_out = 0, error = 0, idle = 0.
- full = 0, empty = 1, almost_full = 0, almost_empty = 1.
- Reset mid-operation discards all contents and any read in flight; a mem_valid_out arriving after reset is ignored.

FSM states:
- INIT: one cycle after reset deassertion; latches th_high/th_low.
  - Valid configuration: th_low < th_high <= 8. Goes to IDLE.
  - Invalid configuration: goes to ERROR.
  - push/pop are ignored in INIT.
- IDLE: fifo_count == 0. An accepted push moves to ACTIVE.
- ACTIVE: fifo_count > 0, or a read is in flight. Returns to IDLE when count reaches 0 and no valid is pending.
- ERROR: sets error = 1. All strobes are forced to 0. push/pop are ignored and pointers are frozen. Exit only via RESET.
- Entry to ERROR from IDLE/ACTIVE:
  - push while full (overflow).
  - pop while empty (underflow).
  - mem_err = 1 in any cycle.

Accept rules (IDLE/ACTIVE only):
- push_ok = push & !full. pop_ok = pop & !empty.
- Push while full goes to ERROR even if pop is also high; the pop in that cycle is not performed.
- Pop while empty goes to ERROR even if push is also high; the push is not performed.
- Simultaneous push_ok & pop_ok: both performed; fifo_count unchanged.

Memory drive (combinational from state/pointers/requests, same cycle as request):
- write = push_ok, address_write = wr_ptr, data = data_in.
- read = pop_ok, address_read = rd_ptr.
- The memory returns mem_valid_out/mem_data_out one cycle after read.

Pointer and count updates (registered):
- wr_ptr += push_ok; rd_ptr += pop_ok; both wrap 7 -> 0 (modulo DEPTH).
- fifo_count += push_ok - pop_ok.

Output path:
- data_out/valid_out are registered from mem_data_out/mem_valid_out.
- Latency pop -> valid_out is 2 cycles; back-to-back pops give back-to-back valid_out.
- data_out holds its last value when valid_out = 0.

Flags (decoded from registered count, so they update the cycle after the push/pop edge):
- full = (count == 8), empty = (count == 0).
- almost_full = (count >= th_high_latched).
- almost_empty = (count <= th_low_latched).

Test Plan:
- Reset, th_high=6, th_low=2, push 0x01..0x08 on 8 consecutive cycles -> write pulses with address_write 0..7, count reaches 8. almost_full rises when count=6; full rises when count=8; error=0.
- From full, pop 8 consecutive cycles -> address_read 0..7. valid_out high 8 cycles starting 2 cycles after the first pop, data_out 0x01..0x08 in order; empty=1 and idle=1 at end.
- Wrap: push 5, pop 5, push 6 -> address_write wraps 5,6,7,0,1,2; popping the 6 returns them in order; count 0 at end.
- Simultaneous push=pop=1 with count=3 for 4 cycles -> count stays 3; write and read strobes both high every cycle; no error.
- Overflow: at count=8 assert push=1, pop=1 -> ERROR state, error=1; write=read=0 thereafter; count frozen at 8 until RESET. Separately, pop at count=0 -> error=1.
- Config/reset: th_low=5, th_high=3 -> ERROR right after INIT. Then RESET mid-stream with 4 entries and a read in flight -> count=0, empty=1, valid_out stays 0.
